uart_tx_feeder: RTL and testbench

Byte queue and launch sequencer placed directly upstream of the UART transmitter. Application logic pushes bytes at any rate into a FIFO. This block pops one byte at a time and drives the transmitter's one-cycle data-valid strobe. It then tracks the transmitter's active/done flags so a new byte is launched only after the previous frame has fully completed.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_byte_fifo.sv | 88 ++++++++
 rtl/uart_tx_feeder.sv | 132 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit feeder
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int STAT_W      = 16;

  typedef enum logic [2:0] {
    SYNC      = 3'd0,
    IDLE      = 3'd1,
    WAIT_ACT  = 3'd2,
    WAIT_DONE = 3'd3,
    WAIT_CLR  = 3'd4
  } feeder_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - byte FIFO with explicit occupancy counter and sticky overflow
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_byte,
  input  logic                   rd_en,
  input  logic                   clr_ovf,
  output logic [UART_DATA_W-1:0] rd_byte,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   drop
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             push_ok;
  logic             pop_ok;

  // Full is judged on the registered count, so a push into a full queue is
  // dropped even when a pop frees a slot on the same edge.
  always_comb begin
    push_ok  = wr_en && !full_q;
    pop_ok   = rd_en && !empty_q;
    drop     = wr_en && full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
    // A drop on the same cycle as a clear wins, so no dropped byte goes unreported.
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wr_byte;
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  assign rd_byte  = mem[rd_ptr_q];
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte queue and launch sequencer ahead of the UART transmitter (option: UART_TX_FEEDER_STATS_EN)
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_n,
  input  logic                   i_Wr_En,
  input  logic [UART_DATA_W-1:0] i_Wr_Byte,
  input  logic                   i_Enable,
  input  logic                   i_Clr_Ovf,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done,
  output logic                   o_Tx_DV,
  output logic [UART_DATA_W-1:0] o_Tx_Byte,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [CNT_W-1:0]       o_Count,
`ifdef UART_TX_FEEDER_STATS_EN
  output logic [STAT_W-1:0]      o_Sent_Cnt,
  output logic [STAT_W-1:0]      o_Drop_Cnt,
`endif
  output logic                   o_Overflow
);

  feeder_state_e          state_q, state_d;
  logic                   tx_dv_q, tx_dv_d;
  logic [UART_DATA_W-1:0] tx_byte_q, tx_byte_d;
  logic                   pop;
  logic [UART_DATA_W-1:0] fifo_rd_byte;
  logic                   fifo_empty;
  logic                   fifo_drop;

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (i_Clock),
    .rst_n    (i_Rst_n),
    .wr_en    (i_Wr_En),
    .wr_byte  (i_Wr_Byte),
    .rd_en    (pop),
    .clr_ovf  (i_Clr_Ovf),
    .rd_byte  (fifo_rd_byte),
    .count    (o_Count),
    .full     (o_Full),
    .empty    (fifo_empty),
    .overflow (o_Overflow),
    .drop     (fifo_drop)
  );

  // Launch sequencing: one byte per complete transmitter handshake.
  always_comb begin
    state_d   = state_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    pop       = 1'b0;
    case (state_q)
      // A frame left running across our reset must finish before we launch.
      SYNC: begin
        if (!i_Tx_Active && !i_Tx_Done) state_d = IDLE;
      end
      IDLE: begin
        if (i_Enable && !fifo_empty) begin
          state_d   = WAIT_ACT;
          tx_dv_d   = 1'b1;
          tx_byte_d = fifo_rd_byte;
          pop       = 1'b1;
        end
      end
      WAIT_ACT: begin
        if (i_Tx_Active || i_Tx_Done) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_Tx_Done) state_d = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!i_Tx_Done) state_d = IDLE;
      end
      default: state_d = SYNC;
    endcase
  end

  // State, launch strobe and held launch byte.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= SYNC;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign o_Tx_DV   = tx_dv_q;
  assign o_Tx_Byte = tx_byte_q;
  assign o_Empty   = fifo_empty;

`ifdef UART_TX_FEEDER_STATS_EN
  logic [STAT_W-1:0] sent_cnt_q, sent_cnt_d;
  logic [STAT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating frame and drop counters; a drop outranks a clear like the overflow flag.
  always_comb begin
    sent_cnt_d = sent_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (state_q == WAIT_DONE && i_Tx_Done && sent_cnt_q != '1)
      sent_cnt_d = sent_cnt_q + 1'b1;
    if (fifo_drop) begin
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (i_Clr_Ovf) begin
      drop_cnt_d = '0;
    end
  end

  // Statistics registers.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sent_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      sent_cnt_q <= sent_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_Sent_Cnt = sent_cnt_q;
  assign o_Drop_Cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - scoreboard bench for uart_tx_feeder (option: UART_TX_FEEDER_STATS_EN)
module tb_uart_tx_feeder;

  localparam int DEPTH   = 16;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int DEPTH4  = 4;
  localparam int CNT4_W  = $clog2(DEPTH4) + 1;
  localparam int ACT_LEN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             wr_en, enable, clr_ovf;
  logic [7:0]       wr_byte;
  logic             tx_active = 1'b0, tx_done = 1'b0;
  logic             tx_dv, full, empty, ovf;
  logic [7:0]       tx_byte;
  logic [CNT_W-1:0] count;

  logic              wr4, en4;
  logic [7:0]        byte4;
  logic              act4 = 1'b0, done4 = 1'b0;
  logic              dv4, full4, empty4, ovf4;
  logic [7:0]        txb4;
  logic [CNT4_W-1:0] count4;

`ifdef UART_TX_FEEDER_STATS_EN
  logic [15:0] sent_cnt, drop_cnt, sent4, drop4;
`endif

  uart_tx_feeder #(.DEPTH(DEPTH)) u_dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_Wr_En     (wr_en),
    .i_Wr_Byte   (wr_byte),
    .i_Enable    (enable),
    .i_Clr_Ovf   (clr_ovf),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .o_Full      (full),
    .o_Empty     (empty),
    .o_Count     (count),
`ifdef UART_TX_FEEDER_STATS_EN
    .o_Sent_Cnt  (sent_cnt),
    .o_Drop_Cnt  (drop_cnt),
`endif
    .o_Overflow  (ovf)
  );

  uart_tx_feeder #(.DEPTH(DEPTH4)) u_dut4 (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_Wr_En     (wr4),
    .i_Wr_Byte   (byte4),
    .i_Enable    (en4),
    .i_Clr_Ovf   (1'b0),
    .i_Tx_Active (act4),
    .i_Tx_Done   (done4),
    .o_Tx_DV     (dv4),
    .o_Tx_Byte   (txb4),
    .o_Full      (full4),
    .o_Empty     (empty4),
    .o_Count     (count4),
`ifdef UART_TX_FEEDER_STATS_EN
    .o_Sent_Cnt  (sent4),
    .o_Drop_Cnt  (drop4),
`endif
    .o_Overflow  (ovf4)
  );

  // Transmitter models: active for ACT_LEN cycles, then done for 2 cycles; not reset by the DUT reset
  int m_cnt = 0;
  always @(posedge clk) begin
    if (tx_dv) begin
      tx_active <= 1'b1; m_cnt <= ACT_LEN;
    end else if (tx_active) begin
      if (m_cnt == 1) begin tx_active <= 1'b0; tx_done <= 1'b1; m_cnt <= 2; end
      else m_cnt <= m_cnt - 1;
    end else if (tx_done) begin
      if (m_cnt == 1) tx_done <= 1'b0;
      else m_cnt <= m_cnt - 1;
    end
  end

  int m4_cnt = 0;
  always @(posedge clk) begin
    if (dv4) begin
      act4 <= 1'b1; m4_cnt <= ACT_LEN;
    end else if (act4) begin
      if (m4_cnt == 1) begin act4 <= 1'b0; done4 <= 1'b1; m4_cnt <= 2; end
      else m4_cnt <= m4_cnt - 1;
    end else if (done4) begin
      if (m4_cnt == 1) done4 <= 1'b0;
      else m4_cnt <= m4_cnt - 1;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] exp4_q[$];
  int rx_cnt = 0, rx4_cnt = 0;
  logic prev_dv = 1'b0, prev_dv4 = 1'b0;

  // Monitor: every launch must match the scoreboard head, find the transmitter idle, and last one cycle
  always @(negedge clk) begin
    if (tx_dv) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL launch_unexpected: got byte %02h, expected no launch", tx_byte);
      end else check("launch_byte", tx_byte, exp_q.pop_front());
      check("launch_tx_idle", {tx_active, tx_done}, 0);
      check("launch_one_cycle", prev_dv, 0);
      rx_cnt++;
    end
    prev_dv = tx_dv;
    if (dv4) begin
      if (exp4_q.size() == 0) begin
        n_total++;
        $display("FAIL launch4_unexpected: got byte %02h, expected no launch", txb4);
      end else check("launch4_byte", txb4, exp4_q.pop_front());
      check("launch4_tx_idle", {act4, done4}, 0);
      check("launch4_one_cycle", prev_dv4, 0);
      rx4_cnt++;
    end
    prev_dv4 = dv4;
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 1000 && !(exp_q.size() == 0 && empty && !tx_active && !tx_done && !tx_dv)) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    check(name, (n < 1000), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int guard;
    bit bad;
    rst_n = 1'b0; wr_en = 1'b0; wr_byte = 8'h00; enable = 1'b0; clr_ovf = 1'b0;
    wr4 = 1'b0; byte4 = 8'h00; en4 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dv", tx_dv, 0);
    check("rst_byte", tx_byte, 8'h00);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1; enable = 1'b1;
    repeat (2) @(negedge clk);

    // single byte latency
    wr_byte = 8'hA5; wr_en = 1'b1; exp_q.push_back(8'hA5);
    @(negedge clk); wr_en = 1'b0;
    check("lat_e0_dv", tx_dv, 0);
    check("lat_e0_count", count, 1);
    @(negedge clk);
    check("lat_e1_dv", tx_dv, 1);
    check("lat_e1_byte", tx_byte, 8'hA5);
    check("lat_e1_count", count, 0);
    @(negedge clk);
    check("dv_width", tx_dv, 0);
    check("byte_held", tx_byte, 8'hA5);
    wait_idle("drain_single");

    // back-to-back pushes
    for (i = 1; i <= 4; i++) begin
      wr_byte = 8'(i); wr_en = 1'b1; exp_q.push_back(8'(i));
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_idle("drain_seq");
    check("seq_rx_cnt", rx_cnt, 5);
    check("seq_count", count, 0);

    // fill past full with launching held off
    enable = 1'b0;
    for (i = 0; i < 18; i++) begin
      wr_byte = 8'(8'h30 + i); wr_en = 1'b1;
      if (i < 16) exp_q.push_back(8'(8'h30 + i));
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    check("fill_ovf", ovf, 1);
`ifdef UART_TX_FEEDER_STATS_EN
    check("fill_drop_cnt", drop_cnt, 2);
`endif
    clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0;
    check("clr_ovf", ovf, 0);
    check("clr_full_kept", full, 1);
`ifdef UART_TX_FEEDER_STATS_EN
    check("clr_drop_cnt", drop_cnt, 0);
`endif

    // push and launch pop on the same edge while full
    enable = 1'b1; wr_byte = 8'hEE; wr_en = 1'b1;
    @(negedge clk); wr_en = 1'b0;
    check("fullpop_count", count, 15);
    check("fullpop_ovf", ovf, 1);
    check("fullpop_dv", tx_dv, 1);
`ifdef UART_TX_FEEDER_STATS_EN
    check("fullpop_drop_cnt", drop_cnt, 1);
`endif
    wait_idle("drain_full");
    check("full_rx_cnt", rx_cnt, 21);

    // reset while the transmitter is mid-frame
    for (i = 0; i < 3; i++) begin
      wr_byte = 8'(8'h51 + i); wr_en = 1'b1;
      if (i == 0) exp_q.push_back(8'h51);
      @(negedge clk);
    end
    wr_en = 1'b0;
    guard = 0;
    while (!tx_active && guard < 50) begin @(negedge clk); guard++; end
    check("rst_mid_active_seen", (guard < 50), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_count", count, 0);
    check("rst_mid_empty", empty, 1);
    check("rst_mid_dv", tx_dv, 0);
    rst_n = 1'b1;
    wr_byte = 8'h54; wr_en = 1'b1; exp_q.push_back(8'h54);
    @(negedge clk); wr_en = 1'b0;
    bad = 1'b0; guard = 0;
    while ((tx_active || tx_done) && guard < 50) begin
      if (tx_dv) bad = 1'b1;
      @(negedge clk); guard++;
    end
    check("rst_mid_no_dv_in_frame", bad, 0);
    wait_idle("drain_after_reset");
    check("rst_rx_cnt", rx_cnt, 23);
    check("rst_final_count", count, 0);

    // pointer wrap on the 4-deep instance, pushing only when not full
    i = 0; guard = 0;
    while (i < 10 && guard < 2000) begin
      if (!full4) begin
        wr4 = 1'b1; byte4 = 8'(8'h10 + i); exp4_q.push_back(8'(8'h10 + i)); i++;
      end else wr4 = 1'b0;
      @(negedge clk); guard++;
    end
    wr4 = 1'b0;
    guard = 0;
    while (guard < 1000 && !(exp4_q.size() == 0 && empty4 && !act4 && !done4)) begin
      @(negedge clk); guard++;
    end
    repeat (3) @(negedge clk);
    check("wrap_drained", (guard < 1000), 1);
    check("wrap_rx_cnt", rx4_cnt, 10);
    check("wrap_ovf", ovf4, 0);
    check("wrap_count", count4, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
